// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : boot_pkg
//  Brief    : Shared types and defaults for the IMEM boot loader.
//             Holds the loader state encoding and the default release delay.
//  Revision : 1.0  initial release
// ============================================================================
package boot_pkg;

    // Loader state encoding; explicit values keep the encoding stable.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Default number of cycles the core stays in reset after loading ends.
    localparam int c_RST_HOLD_DEFAULT = 4;

endpackage : boot_pkg
`default_nettype wire

// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_loader_if
//  Brief    : Program word stream (valid/ready) plus the IMEM write port.
//             slave  = loader side (consumes stream, drives IMEM).
//             master = environment side (stream source, IMEM sink).
//  Revision : 1.0  initial release
// ============================================================================
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
) ();
    import boot_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;
    logic              s_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

endinterface : imem_boot_loader_if
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_loader
//  Brief    : Streams a program into instruction memory and holds the CPU in
//             reset until the load finishes. Overflow (or, optionally, a
//             checksum mismatch) parks the loader in ERR with the CPU held.
//             Optional feature macro: BOOT_CHECKSUM_EN -- the s_last word is
//             a mod-2^32 checksum of the written words instead of code.
//  Revision : 1.0  initial release
// ============================================================================
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int RST_HOLD = c_RST_HOLD_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    imem_boot_loader_if.slave      bus,
    input  wire logic              reload,
    output logic                   cpu_rst,
    output logic                   done,
    output logic                   err,
    output logic [ADDR_W:0]        word_count
);

    localparam int              c_HOLD_W    = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD);
    localparam logic [ADDR_W:0] c_LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_END = c_HOLD_W'(RST_HOLD - 1);

    state_t              r_state,   w_state;
    logic                r_s_ready, w_s_ready;
    logic                r_we,      w_we;
    logic [ADDR_W-1:0]   r_addr,    w_addr;
    logic [31:0]         r_wdata,   w_wdata;
    logic                r_cpu_rst, w_cpu_rst;
    logic                r_done,    w_done;
    logic                r_err,     w_err;
    logic [ADDR_W:0]     r_wc,      w_wc;
    logic [c_HOLD_W-1:0] r_hold,    w_hold;
    logic                w_hs;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]         r_sum,     w_sum;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state   = r_state;
        w_s_ready = r_s_ready;
        w_we      = 1'b0;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_cpu_rst = r_cpu_rst;
        w_done    = r_done;
        w_err     = r_err;
        w_wc      = r_wc;
        w_hold    = r_hold;
`ifdef BOOT_CHECKSUM_EN
        w_sum     = r_sum;
`endif
        w_hs      = bus.s_valid & r_s_ready;

        unique case (r_state)
            ST_IDLE: begin
                w_state   = ST_LOAD;
                w_s_ready = 1'b1;
            end
            ST_LOAD: begin
                if (w_hs) begin
`ifdef BOOT_CHECKSUM_EN
                    if (bus.s_last) begin
                        // Checksum word: compared, never written.
                        w_s_ready = 1'b0;
                        w_hold    = '0;
                        if (bus.s_data == r_sum) begin
                            w_state = ST_HOLD;
                        end else begin
                            w_state = ST_ERR;
                            w_err   = 1'b1;
                        end
                    end else begin
                        w_we    = 1'b1;
                        w_addr  = r_wc[ADDR_W-1:0];
                        w_wdata = bus.s_data;
                        w_wc    = r_wc + 1'b1;
                        w_sum   = r_sum + bus.s_data;
                        if (r_wc == c_LAST_SLOT) begin
                            w_s_ready = 1'b0;
                            w_state   = ST_ERR;
                            w_err     = 1'b1;
                        end
                    end
`else
                    w_we    = 1'b1;
                    w_addr  = r_wc[ADDR_W-1:0];
                    w_wdata = bus.s_data;
                    w_wc    = r_wc + 1'b1;
                    if (bus.s_last) begin
                        w_s_ready = 1'b0;
                        w_hold    = '0;
                        w_state   = ST_HOLD;
                    end else if (r_wc == c_LAST_SLOT) begin
                        // Memory full and the program has not ended.
                        w_s_ready = 1'b0;
                        w_state   = ST_ERR;
                        w_err     = 1'b1;
                    end
`endif
                end
            end
            ST_HOLD: begin
                if (r_hold == c_HOLD_END) begin
                    w_state   = ST_RUN;
                    w_cpu_rst = 1'b0;
                    w_done    = 1'b1;
                end else begin
                    w_hold = r_hold + 1'b1;
                end
            end
            ST_RUN, ST_ERR: begin
                if (reload) begin
                    w_state   = ST_LOAD;
                    w_s_ready = 1'b1;
                    w_cpu_rst = 1'b1;
                    w_done    = 1'b0;
                    w_err     = 1'b0;
                    w_wc      = '0;
`ifdef BOOT_CHECKSUM_EN
                    w_sum     = '0;
`endif
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_wc      <= '0;
            r_hold    <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum     <= '0;
`endif
        end else begin
            r_state   <= w_state;
            r_s_ready <= w_s_ready;
            r_we      <= w_we;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_cpu_rst <= w_cpu_rst;
            r_done    <= w_done;
            r_err     <= w_err;
            r_wc      <= w_wc;
            r_hold    <= w_hold;
`ifdef BOOT_CHECKSUM_EN
            r_sum     <= w_sum;
`endif
        end
    end

    assign bus.s_ready    = r_s_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign cpu_rst        = r_cpu_rst;
    assign done           = r_done;
    assign err            = r_err;
    assign word_count     = r_wc;

endmodule : imem_boot_loader
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_boot_loader
//  Brief    : Self-checking bench for imem_boot_loader (DEPTH=4, RST_HOLD=4).
//             Table of directed programs, reset/reload sequences, then random
//             programs judged by a rule-level model of load outcome.
//             Honours BOOT_CHECKSUM_EN the same way the design does.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 2;
    localparam int RST_HOLD = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic reload;
    logic cpu_rst, done, err;
    logic [ADDR_W:0] word_count;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .reload     (reload),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] prog_w [DEPTH];

    typedef struct {
        int               n;
        bit               last;
        int               gap;
        logic [3:0][31:0] w;
        bit               ok;
        int               wc;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(int n, bit last, int gap, logic [31:0] w0, logic [31:0] w1,
                                logic [31:0] w2, logic [31:0] w3, bit ok, int wc);
        vec_t v;
        v.n = n; v.last = last; v.gap = gap;
        v.w = {w3, w2, w1, w0};
        v.ok = ok; v.wc = wc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " s_ready"},    32'(bus.s_ready),    32'd0);
        chk({tag, " imem_we"},    32'(bus.imem_we),    32'd0);
        chk({tag, " imem_addr"},  32'(bus.imem_addr),  32'd0);
        chk({tag, " imem_wdata"}, bus.imem_wdata,      32'd0);
        chk({tag, " cpu_rst"},    32'(cpu_rst),        32'd1);
        chk({tag, " done"},       32'(done),           32'd0);
        chk({tag, " err"},        32'(err),            32'd0);
        chk({tag, " word_count"}, 32'(word_count),     32'd0);
    endtask

    task automatic restart_reset();
        @(negedge clk);
        rst_n = 1'b0; reload = 1'b0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
        @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
    endtask

    task automatic restart_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload cpu_rst",    32'(cpu_rst),    32'd1);
        chk("reload done",       32'(done),       32'd0);
        chk("reload err",        32'(err),        32'd0);
        chk("reload word_count", 32'(word_count), 32'd0);
        chk("reload s_ready",    32'(bus.s_ready), 32'd1);
    endtask

    // Drive prog_w[0..n-1] and check every write, then the final outcome.
    task automatic run_prog(input string name, input int n, input bit last_fin, input int gap,
                            input bit exp_ok, input int exp_wc);
        int          idx    = 0;
        int          gapc   = 0;
        int          budget = 200;
        int          waddr  = 0;
        bit          pend   = 1'b0;
        bit          ended  = 1'b0;
        bit          is_last;
        logic [31:0] pdata  = '0;
        int          paddr  = 0;
        while (!ended && budget > 0) begin
            @(negedge clk);
            if (pend) begin
                chk({name, " we"},    32'(bus.imem_we),   32'd1);
                chk({name, " addr"},  32'(bus.imem_addr), 32'(paddr));
                chk({name, " wdata"}, bus.imem_wdata,     pdata);
            end else begin
                chk({name, " idle we"}, 32'(bus.imem_we), 32'd0);
            end
            chk({name, " load cpu_rst"}, 32'(cpu_rst), 32'd1);
            pend = 1'b0;
            if (gapc > 0) begin
                bus.s_valid = 1'b0;
                bus.s_data  = $urandom;
                bus.s_last  = $urandom_range(0, 1);
                gapc--;
            end else begin
                is_last     = last_fin && (idx == n - 1);
                bus.s_valid = 1'b1;
                bus.s_data  = prog_w[idx];
                bus.s_last  = is_last;
                if (bus.s_ready) begin
`ifdef BOOT_CHECKSUM_EN
                    if (!is_last) begin
                        pend = 1'b1; pdata = prog_w[idx]; paddr = waddr; waddr++;
                    end
`else
                    pend = 1'b1; pdata = prog_w[idx]; paddr = waddr; waddr++;
`endif
                    if (idx == n - 1) ended = 1'b1;
                    idx++;
                    gapc = gap;
                end
            end
            budget--;
        end
        if (!ended) begin
            n_total++;
            $display("FAIL %s timeout: accepted %0d of %0d words", name, idx, n);
        end
        @(negedge clk);
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        if (pend) begin
            chk({name, " final we"},    32'(bus.imem_we),   32'd1);
            chk({name, " final addr"},  32'(bus.imem_addr), 32'(paddr));
            chk({name, " final wdata"}, bus.imem_wdata,     pdata);
        end else begin
            chk({name, " final no we"}, 32'(bus.imem_we), 32'd0);
        end
        chk({name, " end s_ready"}, 32'(bus.s_ready), 32'd0);
        chk({name, " end cpu_rst"}, 32'(cpu_rst),     32'd1);
        if (exp_ok) begin
            for (int k = 1; k < RST_HOLD; k++) begin
                @(negedge clk);
                chk({name, " hold cpu_rst"}, 32'(cpu_rst), 32'd1);
                chk({name, " hold done"},    32'(done),    32'd0);
                chk({name, " hold we"},      32'(bus.imem_we), 32'd0);
            end
            @(negedge clk);
            chk({name, " run cpu_rst"},    32'(cpu_rst),    32'd0);
            chk({name, " run done"},       32'(done),       32'd1);
            chk({name, " run err"},        32'(err),        32'd0);
            chk({name, " run word_count"}, 32'(word_count), 32'(exp_wc));
        end else begin
            chk({name, " err flag"},       32'(err),        32'd1);
            chk({name, " err word_count"}, 32'(word_count), 32'(exp_wc));
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk({name, " err stays"},    32'(err),         32'd1);
                chk({name, " err cpu_rst"},  32'(cpu_rst),     32'd1);
                chk({name, " err done"},     32'(done),        32'd0);
                chk({name, " err s_ready"},  32'(bus.s_ready), 32'd0);
                chk({name, " err we"},       32'(bus.imem_we), 32'd0);
            end
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < DEPTH; i++) prog_w[i] = v.w[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, gap;
        bit          last, ok;
        int          wc;
        logic [31:0] sum;

        rst_n = 1'b0; reload = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;

`ifdef BOOT_CHECKSUM_EN
        tbl.push_back(mk(3, 1, 0, 32'd5, 32'd7, 32'd12, 32'd0, 1, 2));
        tbl.push_back(mk(3, 1, 0, 32'd5, 32'd7, 32'd13, 32'd0, 0, 2));
        tbl.push_back(mk(3, 1, 2, 32'd5, 32'd7, 32'd12, 32'd0, 1, 2));
        tbl.push_back(mk(1, 1, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 32'd1, 32'd0, 32'd0, 32'd0, 0, 0));
        tbl.push_back(mk(4, 0, 0, 32'd1, 32'd2, 32'd3, 32'd4, 0, 4));
        tbl.push_back(mk(4, 1, 1, 32'hFFFFFFFF, 32'd2, 32'd3, 32'd4, 1, 3));
`else
        tbl.push_back(mk(3, 1, 0, 32'h20010005, 32'h20020007, 32'h00221820, 32'd0, 1, 3));
        tbl.push_back(mk(3, 1, 2, 32'h20010005, 32'h20020007, 32'h00221820, 32'd0, 1, 3));
        tbl.push_back(mk(4, 0, 0, 32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003, 0, 4));
        tbl.push_back(mk(4, 1, 1, 32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003, 1, 4));
        tbl.push_back(mk(1, 1, 0, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 1, 1));
`endif

        // Reset state while rst_n held low.
        @(negedge clk);
        @(negedge clk);
        check_reset("init");
        rst_n = 1'b1;

        // Directed table; restart alternates reset and reload.
        foreach (tbl[i]) begin
            if (i > 0) begin
                if (i % 2 == 1) restart_reload();
                else            restart_reset();
            end
            load_vec(tbl[i]);
            run_prog($sformatf("tbl%0d", i), tbl[i].n, tbl[i].last, tbl[i].gap,
                     tbl[i].ok, tbl[i].wc);
        end

        // Reset in the middle of a load, then a fresh load from address 0.
        restart_reset();
        @(negedge clk);
        bus.s_valid = 1'b1; bus.s_data = 32'h11111111; bus.s_last = 1'b0;
        @(negedge clk);
        chk("midrst w0 we",   32'(bus.imem_we),   32'd1);
        chk("midrst w0 addr", 32'(bus.imem_addr), 32'd0);
        bus.s_data = 32'h22222222;
        @(negedge clk);
        chk("midrst w1 addr", 32'(bus.imem_addr), 32'd1);
        chk("midrst wc",      32'(word_count),    32'd2);
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        rst_n = 1'b1;
        load_vec(tbl[0]);
        run_prog("post_rst", tbl[0].n, tbl[0].last, tbl[0].gap, tbl[0].ok, tbl[0].wc);

        // Reload from RUN with a 2-word program.
        restart_reload();
`ifdef BOOT_CHECKSUM_EN
        prog_w[0] = 32'h00000009; prog_w[1] = 32'h00000009;
        run_prog("reload2", 2, 1'b1, 0, 1'b1, 1);
`else
        prog_w[0] = 32'h12345678; prog_w[1] = 32'h9ABCDEF0;
        run_prog("reload2", 2, 1'b1, 0, 1'b1, 2);
`endif

        // Random programs judged by the outcome rules.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1) restart_reload();
            else                            restart_reset();
            n    = $urandom_range(1, DEPTH);
            last = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            gap  = $urandom_range(0, 2);
            for (int i = 0; i < DEPTH; i++) prog_w[i] = $urandom;
`ifdef BOOT_CHECKSUM_EN
            if (last) begin
                sum = 32'd0;
                for (int i = 0; i < n - 1; i++) sum = sum + prog_w[i];
                ok = 1'($urandom_range(0, 1));
                prog_w[n-1] = ok ? sum : (sum ^ (32'd1 << $urandom_range(0, 31)));
                wc = n - 1;
            end else begin
                ok = 1'b0;
                wc = n;
            end
`else
            sum = 32'd0;
            ok  = last;
            wc  = n;
`endif
            run_prog($sformatf("rnd%0d", it), n, last, gap, ok, wc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_imem_boot_loader
`default_nettype wire
